cardinal_nic_vc: RTL
====================

CARDINAL_NIC_VC -- requirements
Module: cardinal_nic_vc

Interface
REQ-001 SHALL have parameter PAC_WIDTH, default 64, packet width; bit 0 of a packet is its VC bit.
REQ-002 SHALL have parameter IN_DEPTH, default 4, input-FIFO entries; power of two, at least 2.
REQ-003 SHALL have parameter OUT_DEPTH, default 2, entries per output VC FIFO; power of two, at least 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port addr, input, [0:1]: memory-mapped register select.
REQ-007 SHALL have port d_in, input, [0:PAC_WIDTH-1]: PE write data.
REQ-008 SHALL have port d_out, output, [0:PAC_WIDTH-1]: PE read data, combinational.
REQ-009 SHALL have ports nicEn and nicWrEn, inputs, 1 bit each: access enable and write enable.
REQ-010 SHALL have ports net_si (input), net_ri (output) and net_di (input, [0:PAC_WIDTH-1]): the network input channel.
REQ-011 SHALL have ports net_so (output), net_ro (input) and net_do (output, [0:PAC_WIDTH-1]): the network output channel.
REQ-012 SHALL have port net_polarity, input, 1 bit: router polarity.

Function
REQ-013 SHALL make net_ri equal to NOT in_full; a push SHALL occur on any edge where net_si and net_ri are both high.
REQ-014 PE read access (nicEn=1, nicWrEn=0):
- addr 00: d_out SHALL present the input-FIFO head.
- If the FIFO is non-empty, the head SHALL pop at the edge.
- If empty: d_out=0 and no pop.
REQ-015 Push and pop on the input FIFO in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-016 addr 01 read SHALL return in_count in bits [PAC_WIDTH-2-$clog2(IN_DEPTH)-1 : PAC_WIDTH-3], in_full in bit PAC_WIDTH-2 and in_nonempty in bit PAC_WIDTH-1; all other bits 0.
REQ-017 PE write (nicEn=1, nicWrEn=1, addr 10) SHALL push d_in into the even VC FIFO if d_in[0]=0, otherwise into the odd VC FIFO.
REQ-018 A write to a full VC FIFO SHALL be dropped and SHALL set the sticky ovf flag.
REQ-019 addr 11 read SHALL return even_full in bit PAC_WIDTH-1, odd_full in bit PAC_WIDTH-2 and ovf in bit PAC_WIDTH-3; all other bits 0.
REQ-020 An addr 11 read SHALL clear ovf at the edge; if an overflow occurs in the same cycle, set SHALL win.
REQ-021 All other accesses SHALL give d_out=0 and change no state; a write to addr 00, 01 or 11 is ignored.
REQ-022 The eligible VC SHALL be even when net_polarity=1 and odd when net_polarity=0.
REQ-023 Output channel:
- net_do SHALL equal the eligible FIFO head, or 0 when that FIFO is empty.
- net_so SHALL equal net_ro AND eligible FIFO non-empty.
- The eligible FIFO SHALL pop on every edge where net_so=1.
REQ-024 The ineligible VC FIFO SHALL never block the eligible one, so there is no head-of-line blocking across VCs.
REQ-025 A PE push and a network pop on the same VC FIFO in the same cycle SHALL both take effect, provided the FIFO was not full before the edge.
REQ-026 FIFO pointers SHALL wrap modulo depth; occupancy counters SHALL be $clog2(depth)+1 bits wide.
REQ-027 Packet data SHALL pass through unmodified; FIFO latency is one cycle from push to head-visible.

Reset
REQ-028 While reset_n=0, all FIFOs SHALL be empty and ovf SHALL be 0, asynchronously.
REQ-029 While reset_n=0, outputs SHALL be net_ri=0, net_so=0, net_do=0 and d_out=0.
REQ-030 net_ri SHALL rise in the first cycle after reset_n deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all queued packets without emitting a partial transfer.

Structure
REQ-032 A shared package nic_pkg SHALL hold the address constants (ADDR_IN_DATA=00, ADDR_IN_STAT=01, ADDR_OUT_DATA=10, ADDR_OUT_STAT=11) and the status bit-position constants.
REQ-033 A single sub-module nic_fifo (parameters WIDTH, DEPTH) SHALL implement all three FIFOs: a synchronous FIFO with async active-low reset and full/empty/count outputs.

Verification
REQ-034 Network pushes 0x0000_0000_0000_00A1..A4 with the PE idle: net_ri=0 after the 4th push; addr 01 read returns count=4 and full=1.
REQ-035 Four addr 00 reads SHALL return A1, A2, A3, A4 in order; a 5th read SHALL return 0 with count unchanged at 0.
REQ-036 net_polarity=1, net_ro=1, PE writes odd packet 0x8000...0001: net_so stays 0. A subsequent even packet 0x0000...0002 SHALL appear on net_do with net_so=1 the next cycle.
REQ-037 Three even writes with net_ro=0 (OUT_DEPTH=2): the 3rd write is dropped and an addr 11 read returns bits even_full=1 and ovf=1. A second addr 11 read SHALL return ovf=0.
REQ-038 Simultaneous net_si push and PE pop at count=2: count SHALL remain 2 and data order SHALL be preserved.
REQ-039 reset_n pulled low with 2 packets queued in each FIFO: all FIFOs SHALL be empty and net_so=0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/nic_pkg.sv
// Shared constants for the cardinal NIC: PE register map and status-word field positions.
// Field positions count up from the last bus bit: offset k sits on bit PAC_WIDTH-1-k.
package nic_pkg;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    localparam int STAT_IN_NONEMPTY = 0;
    localparam int STAT_IN_FULL     = 1;
    localparam int STAT_IN_COUNT    = 2;

    localparam int STAT_EVEN_FULL   = 0;
    localparam int STAT_ODD_FULL    = 1;
    localparam int STAT_OVF         = 2;

endpackage

// File: rtl/nic_fifo.sv
// Synchronous FIFO, head visible one cycle after push, combinational read port.
// Push while full and pop while empty are ignored; push+pop when not full both take effect.
module nic_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        empty    = (count_q == '0);
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Power-of-two depth lets the pointers wrap by natural overflow.
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/cardinal_nic_vc.sv
// Cardinal NIC with even/odd virtual-channel output queues; register reads are combinational, FIFO latency one cycle.
// Network input throttled by net_ri (input FIFO not full); output VC chosen by router polarity, popped on net_so.
module cardinal_nic_vc
    import nic_pkg::*;
#(
    parameter int PAC_WIDTH = 64,
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [0:1]           addr,
    input  logic [0:PAC_WIDTH-1] d_in,
    output logic [0:PAC_WIDTH-1] d_out,
    input  logic                 nicEn,
    input  logic                 nicWrEn,
    input  logic                 net_si,
    output logic                 net_ri,
    input  logic [0:PAC_WIDTH-1] net_di,
    output logic                 net_so,
    input  logic                 net_ro,
    output logic [0:PAC_WIDTH-1] net_do,
    input  logic                 net_polarity
);

    localparam int IN_CW  = $clog2(IN_DEPTH) + 1;
    localparam int OUT_CW = $clog2(OUT_DEPTH) + 1;

    logic [PAC_WIDTH-1:0] in_head, even_head, odd_head;
    logic                 in_full, in_empty, even_full, even_empty, odd_full, odd_empty;
    logic [IN_CW-1:0]     in_count;
    logic [OUT_CW-1:0]    even_count, odd_count;

    logic                 rd_en, wr_en, in_push, in_pop, out_wr, even_push, odd_push;
    logic                 even_pop, odd_pop, ovf_set, stat_rd;
    logic                 ovf_q, ovf_d;
    logic [PAC_WIDTH-1:0] in_stat, out_stat;

    nic_fifo #(.WIDTH(PAC_WIDTH), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk(clk), .rst_n(reset_n), .push(in_push), .pop(in_pop), .wdata(net_di),
        .rdata(in_head), .full(in_full), .empty(in_empty), .count(in_count)
    );

    nic_fifo #(.WIDTH(PAC_WIDTH), .DEPTH(OUT_DEPTH)) u_even_fifo (
        .clk(clk), .rst_n(reset_n), .push(even_push), .pop(even_pop), .wdata(d_in),
        .rdata(even_head), .full(even_full), .empty(even_empty), .count(even_count)
    );

    nic_fifo #(.WIDTH(PAC_WIDTH), .DEPTH(OUT_DEPTH)) u_odd_fifo (
        .clk(clk), .rst_n(reset_n), .push(odd_push), .pop(odd_pop), .wdata(d_in),
        .rdata(odd_head), .full(odd_full), .empty(odd_empty), .count(odd_count)
    );

    // net_ri is forced low during reset since the cleared input FIFO would otherwise look ready.
    assign net_ri  = reset_n & ~in_full;
    assign in_push = net_si & net_ri;

    always_comb begin
        rd_en     = nicEn & ~nicWrEn;
        wr_en     = nicEn & nicWrEn;
        in_pop    = rd_en & (addr == ADDR_IN_DATA) & ~in_empty;
        stat_rd   = rd_en & (addr == ADDR_OUT_STAT);
        out_wr    = wr_en & (addr == ADDR_OUT_DATA);
        even_push = out_wr & ~d_in[0];
        odd_push  = out_wr & d_in[0];
        ovf_set   = (even_push & even_full) | (odd_push & odd_full);
        ovf_d     = ovf_q;
        if (stat_rd) ovf_d = 1'b0;
        if (ovf_set) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ovf_q <= 1'b0;
        else          ovf_q <= ovf_d;
    end

    always_comb begin
        in_stat                             = '0;
        in_stat[STAT_IN_NONEMPTY]           = ~in_empty;
        in_stat[STAT_IN_FULL]               = in_full;
        in_stat[STAT_IN_COUNT +: IN_CW]     = in_count;
        out_stat                            = '0;
        out_stat[STAT_EVEN_FULL]            = even_full;
        out_stat[STAT_ODD_FULL]             = odd_full;
        out_stat[STAT_OVF]                  = ovf_q;
        d_out = '0;
        if (rd_en) begin
            case (addr)
                ADDR_IN_DATA:  d_out = in_empty ? '0 : in_head;
                ADDR_IN_STAT:  d_out = in_stat;
                ADDR_OUT_STAT: d_out = out_stat;
                default:       d_out = '0;
            endcase
        end
    end

    // Polarity 1 serves the even VC, 0 the odd VC; the idle VC cannot stall the served one.
    always_comb begin
        if (net_polarity) begin
            net_so = net_ro & (even_count != '0);
            net_do = even_empty ? '0 : even_head;
        end else begin
            net_so = net_ro & (odd_count != '0);
            net_do = odd_empty ? '0 : odd_head;
        end
        even_pop = net_so & net_polarity;
        odd_pop  = net_so & ~net_polarity;
    end

endmodule
